// File: rtl/f1_reaction_timer.sv
// Reaction timer for the F1 start-light game: arms on a light sequence, times the
// button press after lights out. Optional best-time tracking via F1_BEST_TIME_EN.
module f1_reaction_timer #(
  parameter int CNT_W  = 16,
  parameter int MAX_MS = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic [CNT_W-1:0] reaction_ms,
  output logic             time_valid,
  output logic             jump_start,
  output logic             timeout,
`ifdef F1_BEST_TIME_EN
  output logic [CNT_W-1:0] best_ms,
`endif
  output logic             timing
);

  typedef enum logic [2:0] {IDLE, ARMED, RUNNING, DONE, FOUL} state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       lights_q;
  logic             btn_q;
  logic             press, start, lights_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MAX_C) ? MAX_C : v + CNT_W'(1);
  endfunction

  assign press      = btn & ~btn_q;
  assign start      = (lights_q == 8'h00) & (lights != 8'h00);
  assign lights_out = (lights_q == 8'hFF) & (lights == 8'h00);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: if (start) state_d = ARMED;
      ARMED: begin
        if (press) begin
          state_d  = FOUL;
          result_d = '0;
        end else if (lights_out) begin
          state_d = RUNNING;
          count_d = '0;
        end else if ((lights == 8'h00) && (lights_q != 8'hFF)) begin
          state_d = IDLE;
        end
      end
      RUNNING: begin
        // A press wins over a tick arriving in the same cycle.
        if (press) begin
          state_d  = DONE;
          result_d = count_q;
        end else if (tick) begin
          count_d = sat_inc(count_q);
          if (sat_inc(count_q) == MAX_C) begin
            state_d   = DONE;
            result_d  = MAX_C;
            timeout_d = 1'b1;
          end
        end
      end
      DONE, FOUL: begin
        if (start) begin
          state_d   = ARMED;
          result_d  = '0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      lights_q  <= 8'h00;
      btn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      lights_q  <= lights;
      btn_q     <= btn;
    end
  end

`ifdef F1_BEST_TIME_EN
  logic [CNT_W-1:0] best_q, best_d;

  // Only genuine presses (not timeouts) can improve the record.
  always_comb begin
    best_d = best_q;
    if ((state_q == RUNNING) && (state_d == DONE) && !timeout_d && (result_d < best_q))
      best_d = result_d;
  end

  always_ff @(posedge clk) begin
    if (rst) best_q <= '1;
    else     best_q <= best_d;
  end

  assign best_ms = best_q;
`endif

  assign reaction_ms = result_q;
  assign time_valid  = (state_q == DONE);
  assign jump_start  = (state_q == FOUL);
  assign timing      = (state_q == RUNNING);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Randomized bench for f1_reaction_timer; expected results come from counting ticks
// between lights out and the press in the stimulus itself.
module tb_f1_reaction_timer;
  localparam int CNT_W  = 16;
  localparam int MAX_MS = 60;

  logic             clk = 1'b0;
  logic             rst, tick, btn;
  logic [7:0]       lights;
  logic [CNT_W-1:0] reaction_ms;
  logic             time_valid, jump_start, timeout, timing;
`ifdef F1_BEST_TIME_EN
  logic [CNT_W-1:0] best_ms;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int best     = (1 << CNT_W) - 1;

  f1_reaction_timer #(.CNT_W(CNT_W), .MAX_MS(MAX_MS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
    .reaction_ms(reaction_ms), .time_valid(time_valid), .jump_start(jump_start),
    .timeout(timeout),
`ifdef F1_BEST_TIME_EN
    .best_ms(best_ms),
`endif
    .timing(timing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int r, input bit tv, input bit js,
                            input bit to, input bit tm);
    check_eq({tag, ".reaction_ms"}, 32'(reaction_ms), r);
    check_eq({tag, ".time_valid"},  32'(time_valid),  32'(tv));
    check_eq({tag, ".jump_start"},  32'(jump_start),  32'(js));
    check_eq({tag, ".timeout"},     32'(timeout),     32'(to));
    check_eq({tag, ".timing"},      32'(timing),      32'(tm));
  endtask

  task automatic check_best(input string tag);
`ifdef F1_BEST_TIME_EN
    check_eq({tag, ".best_ms"}, 32'(best_ms), best);
`endif
  endtask

  task automatic apply(input logic [7:0] l, input logic t, input logic b);
    lights = l;
    tick   = t;
    btn    = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Thermometer ramp 01..FF; jstep 1..7 presses (and holds) from that step on.
  task automatic ramp(input int jstep);
    logic [7:0] pat;
    int hold;
    apply(8'h00, rbit(), 1'b0);
    for (int i = 0; i < 8; i++) begin
      pat  = 8'((1 << (i + 1)) - 1);
      hold = (i == 7) ? 1 : $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        apply(pat, rbit(), (jstep > 0) && (i >= jstep));
        if (i == 0 && h == 0) check_outs("armed", 0, 0, 0, 0, 0);
        if (jstep > 0 && jstep <= 7 && i == jstep && h == 0)
          check_outs("jump", 0, 0, 1, 0, 0);
      end
    end
  endtask

  // jstep: 0 none, 1..7 press during ramp, 8 press on the lights-out cycle.
  task automatic run_seq(input int jstep, input int target, input bit coinc);
    int cnt, er;
    bit eto, done, p, t;
    ramp(jstep);
    apply(8'h00, rbit(), jstep > 0);
    if (jstep > 0) begin
      check_outs("foul", 0, 0, 1, 0, 0);
      repeat ($urandom_range(2, 5)) apply(8'h00, rbit(), 1'b1);
      check_outs("foul_hold", 0, 0, 1, 0, 0);
      check_best("foul");
      return;
    end
    check_outs("running", 0, 0, 0, 0, 1);
    cnt = 0; er = 0; eto = 0; done = 0;
    for (int k = 0; k < 4 * MAX_MS + 100 && !done; k++) begin
      p = (cnt == target);
      t = (p && coinc) ? 1'b1 : rbit();
      apply(8'h00, t, p);
      if (p) begin
        er = cnt; done = 1;
      end else if (t) begin
        cnt++;
        if (cnt == MAX_MS) begin er = MAX_MS; eto = 1; done = 1; end
      end
    end
    check_eq("run_done", 32'(done), 32'd1);
    if (!eto && er < best) best = er;
    check_outs("result", er, 1, 0, eto, 0);
    check_best("result");
    apply(8'h00, rbit(), 1'b0);
    repeat ($urandom_range(0, 3)) apply(8'h00, rbit(), 1'b0);
    apply(8'h00, rbit(), 1'b1);
    apply(8'h00, rbit(), 1'b0);
    check_outs("late_press", er, 1, 0, eto, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; btn = 1'b0; lights = 8'h00;
    apply(8'h00, 1'b0, 1'b0);
    apply(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0);
    check_best("reset");

    // Reset in the middle of a running count.
    ramp(0);
    apply(8'h00, 1'b0, 1'b0);
    repeat (5) apply(8'h00, 1'b1, 1'b0);
    check_outs("pre_rst", 0, 0, 0, 0, 1);
    rst = 1'b1;
    apply(8'h00, 1'b1, 1'b0);
    apply(8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    check_outs("rst_mid", 0, 0, 0, 0, 0);

    run_seq(0, 37, 0);
    run_seq(2, 0, 0);
    run_seq(8, 0, 0);
    run_seq(0, 12, 1);
    run_seq(0, 999, 0);

    // Aborted sequence returns to idle; a press there is ignored.
    apply(8'h00, 1'b0, 1'b0);
    apply(8'h01, 1'b0, 1'b0);
    apply(8'h03, 1'b0, 1'b0);
    apply(8'h00, 1'b0, 1'b0);
    check_outs("abort", 0, 0, 0, 0, 0);
    apply(8'h00, 1'b0, 1'b1);
    apply(8'h00, 1'b0, 1'b0);
    check_outs("idle_press", 0, 0, 0, 0, 0);

    // Best-time sequence after a fresh reset.
    rst = 1'b1;
    apply(8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    best = (1 << CNT_W) - 1;
    check_best("best_rst");
    run_seq(0, 50, 0);
    run_seq(3, 0, 0);
    run_seq(0, 30, 0);
    run_seq(0, 999, 0);
    run_seq(0, 40, 0);

    for (int n = 0; n < 30; n++) begin
      int js;
      js = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
      run_seq(js, $urandom_range(0, MAX_MS + 5), rbit());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
